reg_unit_pipe: RTL and testbench

Parametrised multi-stage register unit for the PE tile, generalising the single-stage dff/dffe/sdff/sdffe register primitives into one configurable delay line. It provides a run-time selectable latency (0..DEPTH), optional enable gating, a configurable synchronous reset value, per-stage valid tracking with flush, and an occupancy count. It sits on the PE datapath between the routing muxes and the ALU/output ports. Its configuration inputs are driven from tile config bits.

---
 rtl/reg_unit_pipe.sv | 95 +++++++++
 tb/tb_reg_unit_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_unit_pipe.sv
// Configurable delay line for the PE tile datapath.
// Provides selectable latency 0..DEPTH, enable gating, reset value, valid tracking with flush, and occupancy.

module reg_unit_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             advance,
    input  logic             flush,
    input  logic [WIDTH-1:0] rst_value,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] s,
    output logic             v
);
    always_ff @(posedge clk) begin
        if (srst) begin
            s <= rst_value;
            v <= 1'b0;
        end else if (advance) begin
            s <= d;
            v <= d_valid;
        end else if (flush) begin
            v <= 1'b0;
        end
    end
endmodule

module reg_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             SRST,
    input  logic [LW-1:0]    cfg_latency,
    input  logic             cfg_en_mode,
    input  logic [WIDTH-1:0] cfg_rst_value,
    input  logic             EN,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] D,
    input  logic             D_valid,
    output logic [WIDTH-1:0] Q,
    output logic             Q_valid,
    output logic [LW-1:0]    occupancy
);
    logic [DEPTH-1:0][WIDTH-1:0] s;
    logic [DEPTH-1:0][WIDTH-1:0] s_in;
    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            v_in;
    logic                        advance;
    logic [LW-1:0]               lat_eff;

    assign advance = cfg_en_mode ? EN : 1'b1;
    assign lat_eff = (cfg_latency > LW'(DEPTH)) ? LW'(DEPTH) : cfg_latency;

    // Every physical stage shifts regardless of latency, so a latency change never loses or reorders data.
    // A flush concurrent with advance keeps only the newly accepted word valid.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign s_in[g] = D;
            assign v_in[g] = D_valid;
        end else begin : g_tail
            assign s_in[g] = s[g-1];
            assign v_in[g] = v[g-1] & ~FLUSH;
        end

        reg_unit_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (CLK),
            .srst     (SRST),
            .advance  (advance),
            .flush    (FLUSH),
            .rst_value(cfg_rst_value),
            .d        (s_in[g]),
            .d_valid  (v_in[g]),
            .s        (s[g]),
            .v        (v[g])
        );
    end

    always_comb begin
        Q         = D;
        Q_valid   = D_valid;
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (LW'(i) < lat_eff)
                occupancy = occupancy + LW'(v[i]);
            if (lat_eff == LW'(i + 1)) begin
                Q       = s[i];
                Q_valid = v[i];
            end
        end
    end
endmodule

// File: tb/tb_reg_unit_pipe.sv
// Self-checking bench for reg_unit_pipe: scoreboard queue per scenario, inline comparisons.

module tb_reg_unit_pipe;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic             SRST;
    logic [LW-1:0]    cfg_latency;
    logic             cfg_en_mode;
    logic [WIDTH-1:0] cfg_rst_value;
    logic             EN;
    logic             FLUSH;
    logic [WIDTH-1:0] D;
    logic             D_valid;
    logic [WIDTH-1:0] Q;
    logic             Q_valid;
    logic [LW-1:0]    occupancy;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] sb[$];

    reg_unit_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .SRST(SRST), .cfg_latency(cfg_latency), .cfg_en_mode(cfg_en_mode),
        .cfg_rst_value(cfg_rst_value), .EN(EN), .FLUSH(FLUSH), .D(D), .D_valid(D_valid),
        .Q(Q), .Q_valid(Q_valid), .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [WIDTH-1:0] rv);
        SRST = 1'b1; FLUSH = 1'b0; D_valid = 1'b0; D = '0; EN = 1'b0;
        cfg_rst_value = rv;
        tick();
        tick();
        SRST = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        cfg_latency = 3; cfg_en_mode = 1'b0;
        do_reset(32'hDEADBEEF);
        checks++;
        if (Q !== 32'hDEADBEEF || Q_valid !== 1'b0 || occupancy !== '0) begin
            failures++;
            $display("FAIL reset: Q=%h Qv=%b occ=%0d required Q=deadbeef Qv=0 occ=0", Q, Q_valid, occupancy);
        end
        tick();
        checks++;
        if (Q !== 32'hDEADBEEF || Q_valid !== 1'b0 || occupancy !== '0) begin
            failures++;
            $display("FAIL reset_release: Q=%h Qv=%b occ=%0d required Q=deadbeef Qv=0 occ=0", Q, Q_valid, occupancy);
        end
    endtask

    // Streams words 1..n at the given latency setting, checks first-valid edge, order, steady occupancy.
    task automatic stream_check(input string name, input logic [LW-1:0] lat, input int exp_l, input int n);
        int first_edge;
        int edge_no;
        logic [WIDTH-1:0] e;
        cfg_latency = lat; cfg_en_mode = 1'b0;
        do_reset('0);
        first_edge = -1;
        edge_no = 0;
        for (int k = 1; k <= n + exp_l; k++) begin
            D_valid = (k <= n);
            D = WIDTH'(k);
            if (k <= n) sb.push_back(WIDTH'(k));
            tick();
            edge_no++;
            if (Q_valid === 1'b1) begin
                if (first_edge < 0) first_edge = edge_no;
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                checks++;
                if (Q !== e) begin
                    failures++;
                    $display("FAIL %s_data: edge %0d Q=%h required %h", name, edge_no, Q, e);
                end
            end
            if (edge_no == exp_l + 2) begin
                checks++;
                if (occupancy !== LW'(exp_l)) begin
                    failures++;
                    $display("FAIL %s_occ: occ=%0d required %0d", name, occupancy, exp_l);
                end
            end
        end
        checks++;
        if (first_edge != exp_l) begin
            failures++;
            $display("FAIL %s_latency: first valid at edge %0d required %0d", name, first_edge, exp_l);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d words left required 0", name, sb.size());
        end
    endtask

    task automatic test_fixed_latency();
        stream_check("fixed", 3'd4, 4, 10);
        stream_check("lat2", 3'd2, 2, 6);
    endtask

    task automatic test_enable_stall();
        cfg_latency = 2; cfg_en_mode = 1'b1;
        do_reset(32'h5A5A5A5A);
        D = 32'hA5; D_valid = 1'b1; EN = 1'b1;
        tick();
        D = 32'h11; D_valid = 1'b1; EN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (Q !== 32'h5A5A5A5A || Q_valid !== 1'b0 || occupancy !== 3'd1) begin
                failures++;
                $display("FAIL stall: cyc %0d Q=%h Qv=%b occ=%0d required 5a5a5a5a/0/1", k, Q, Q_valid, occupancy);
            end
        end
        D_valid = 1'b0; EN = 1'b1;
        tick();
        checks++;
        if (Q !== 32'hA5 || Q_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: Q=%h Qv=%b required a5/1", Q, Q_valid);
        end
        EN = 1'b0;
    endtask

    task automatic test_flush();
        cfg_latency = 3; cfg_en_mode = 1'b0;
        do_reset('0);
        for (int k = 1; k <= 3; k++) begin
            D = WIDTH'(k); D_valid = 1'b1;
            tick();
        end
        checks++;
        if (occupancy !== 3'd3 || Q !== 32'd1 || Q_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre: occ=%0d Q=%h Qv=%b required 3/1/1", occupancy, Q, Q_valid);
        end
        FLUSH = 1'b1; D = 32'h77; D_valid = 1'b1;
        sb.push_back(32'h77);
        tick();
        FLUSH = 1'b0; D_valid = 1'b0;
        checks++;
        if (occupancy !== 3'd1 || Q_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_occ: occ=%0d Qv=%b required 1/0", occupancy, Q_valid);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            if (Q_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0 || Q !== sb[0]) begin
                    failures++;
                    $display("FAIL flush_stale: Q=%h valid required only 77", Q);
                end else void'(sb.pop_front());
            end
        end
        checks++;
        if (sb.size() != 0 || Q !== 32'h77) begin
            failures++;
            $display("FAIL flush_emerge: Q=%h left=%0d required 77 emerged", Q, sb.size());
        end
    endtask

    task automatic test_bypass_clamp();
        logic [WIDTH-1:0] r;
        cfg_latency = 0; cfg_en_mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            r = $urandom;
            D = r; D_valid = k[0];
            #1;
            checks++;
            if (Q !== r || Q_valid !== k[0] || occupancy !== '0) begin
                failures++;
                $display("FAIL bypass: Q=%h Qv=%b occ=%0d required %h/%b/0", Q, Q_valid, occupancy, r, k[0]);
            end
            tick();
        end
        stream_check("clamp", 3'd7, 4, 6);
    endtask

    task automatic test_latency_switch();
        cfg_latency = 4; cfg_en_mode = 1'b0;
        do_reset('0);
        for (int k = 1; k <= 10; k++) begin
            D = WIDTH'(k); D_valid = 1'b1;
            tick();
        end
        checks++;
        if (Q !== 32'd7 || Q_valid !== 1'b1) begin
            failures++;
            $display("FAIL switch_pre: Q=%h Qv=%b required 7/1", Q, Q_valid);
        end
        cfg_latency = 1;
        #1;
        checks++;
        if ($isunknown({Q, Q_valid, occupancy}) || Q !== 32'd10 || Q_valid !== 1'b1 || occupancy > 3'd1) begin
            failures++;
            $display("FAIL switch: Q=%h Qv=%b occ=%0d required a/1/<=1", Q, Q_valid, occupancy);
        end
        D = 32'd11;
        tick();
        checks++;
        if (Q !== 32'd11 || Q_valid !== 1'b1) begin
            failures++;
            $display("FAIL switch_next: Q=%h Qv=%b required b/1", Q, Q_valid);
        end
    endtask

    task automatic test_srst_midstream();
        cfg_latency = 2; cfg_en_mode = 1'b0;
        do_reset(32'h0BAD0BAD);
        for (int k = 1; k <= 3; k++) begin
            D = WIDTH'(k); D_valid = 1'b1;
            tick();
        end
        SRST = 1'b1;
        tick();
        SRST = 1'b0;
        checks++;
        if (Q !== 32'h0BAD0BAD || Q_valid !== 1'b0 || occupancy !== '0) begin
            failures++;
            $display("FAIL srst_mid: Q=%h Qv=%b occ=%0d required 0bad0bad/0/0", Q, Q_valid, occupancy);
        end
        D = 32'h99; D_valid = 1'b1;
        tick();
        D_valid = 1'b0;
        tick();
        checks++;
        if (Q !== 32'h99 || Q_valid !== 1'b1 || occupancy !== 3'd1) begin
            failures++;
            $display("FAIL srst_first: Q=%h Qv=%b occ=%0d required 99/1/1", Q, Q_valid, occupancy);
        end
    endtask

    initial begin
        SRST = 1'b1; cfg_latency = 3; cfg_en_mode = 1'b0; cfg_rst_value = '0;
        EN = 1'b0; FLUSH = 1'b0; D = '0; D_valid = 1'b0;
        test_reset();
        test_fixed_latency();
        test_enable_stall();
        test_flush();
        test_bypass_clamp();
        test_latency_switch();
        test_srst_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
